sram1rw512x32_arbiter: RTL and testbench

//   Sequences one SRAM1RW512x32 single-port macro and shares it between two requesters (port 0, port 1).

---
 rtl/sram1rw512x32_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram1rw512x32_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram1rw512x32_arbiter.sv
// sram1rw512x32_arbiter
// Shares one single-port 512x32 SRAM macro between two requesters.
// After reset the whole array is optionally filled with INIT_VALUE. After that
// the block issues one access per cycle, with round-robin arbitration between
// the ports. Read data comes back one cycle after acceptance, straight from the
// macro output.
module sram1rw512x32_arbiter #(
  parameter int                ADDR_W     = 9,
  parameter int                DATA_W     = 32,
  parameter int                INIT_EN    = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_write,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_resp_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_write,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] fill_addr_r;
  logic              rr_ptr_r;
  logic              p0_resp_valid_r;
  logic              p1_resp_valid_r;
  logic              init_done_r;

  logic              run_s;
  logic              grant0_s;
  logic              grant1_s;

  // Arbitration: lone requester wins, otherwise rr_ptr picks the winner.
  always_comb begin
    run_s    = reset_n & (state_r == ST_RUN);
    grant0_s = run_s & p0_req_valid & (~p1_req_valid | ~rr_ptr_r);
    grant1_s = run_s & p1_req_valid & (~p0_req_valid |  rr_ptr_r);
  end

  // Macro pin drive: fill writes during INIT, granted request during RUN.
  // The macro samples these pins on the same edge as the port handshake.
  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_oeb = 1'b1;
    sram_a   = {ADDR_W{1'b0}};
    sram_i   = {DATA_W{1'b0}};
    if (!reset_n) begin
      sram_csb = 1'b1;
    end else if (state_r == ST_INIT) begin
      sram_csb = 1'b0;
      sram_web = 1'b0;
      sram_a   = fill_addr_r;
      sram_i   = INIT_VALUE;
    end else if (grant0_s) begin
      sram_csb = 1'b0;
      sram_web = ~p0_req_write;
      sram_oeb = p0_req_write;
      sram_a   = p0_req_addr;
      sram_i   = p0_req_wdata;
    end else if (grant1_s) begin
      sram_csb = 1'b0;
      sram_web = ~p1_req_write;
      sram_oeb = p1_req_write;
      sram_a   = p1_req_addr;
      sram_i   = p1_req_wdata;
    end else begin
      sram_csb = 1'b1;
    end
  end

  // Port-side outputs. The response valids are also gated by reset_n so an
  // in-flight response is dropped as soon as reset is asserted.
  always_comb begin
    p0_req_ready  = grant0_s;
    p1_req_ready  = grant1_s;
    p0_resp_valid = p0_resp_valid_r & reset_n;
    p1_resp_valid = p1_resp_valid_r & reset_n;
    p0_resp_rdata = sram_o;
    p1_resp_rdata = sram_o;
    init_done     = init_done_r;
  end

  // Control FSM: fill sequencing, round-robin pointer and response tracking.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r         <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      fill_addr_r     <= {ADDR_W{1'b0}};
      rr_ptr_r        <= 1'b0;
      p0_resp_valid_r <= 1'b0;
      p1_resp_valid_r <= 1'b0;
      init_done_r     <= (INIT_EN == 0);
    end else begin
      case (state_r)
        ST_INIT: begin
          p0_resp_valid_r <= 1'b0;
          p1_resp_valid_r <= 1'b0;
          fill_addr_r     <= fill_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (fill_addr_r == {ADDR_W{1'b1}}) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end
        end
        ST_RUN: begin
          p0_resp_valid_r <= grant0_s & ~p0_req_write;
          p1_resp_valid_r <= grant1_s & ~p1_req_write;
          if (grant0_s) begin
            rr_ptr_r <= 1'b1;
          end else if (grant1_s) begin
            rr_ptr_r <= 1'b0;
          end
        end
        default: begin
          state_r         <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
          fill_addr_r     <= {ADDR_W{1'b0}};
          p0_resp_valid_r <= 1'b0;
          p1_resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram1rw512x32_arbiter.sv
// Directed bench for sram1rw512x32_arbiter with a behavioural SRAM macro.
module tb_sram1rw512x32_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        p0_req_valid, p0_req_ready, p0_req_write;
  logic [8:0]  p0_req_addr;
  logic [31:0] p0_req_wdata;
  logic        p0_resp_valid;
  logic [31:0] p0_resp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_write;
  logic [8:0]  p1_req_addr;
  logic [31:0] p1_req_wdata;
  logic        p1_resp_valid;
  logic [31:0] p1_resp_rdata;
  logic        init_done;
  logic [8:0]  sram_a;
  logic [31:0] sram_i;
  logic [31:0] sram_o;
  logic        sram_csb, sram_web, sram_oeb;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [512];

  sram1rw512x32_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .init_done(init_done),
    .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb)
  );

  always #5 clock = ~clock;

  // Behavioural macro: registered read, write updates array, idle holds output.
  always @(posedge clock) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else if (!sram_oeb) sram_o <= mem[sram_a];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Check fill cycles from..to-1; ends at start of cycle 'to'.
  task automatic fill_cycles(input int from, input int to);
    for (int c = from; c < to; c++) begin
      @(negedge clock);
      check_eq("fill_done",  32'(init_done), 32'd0);
      check_eq("fill_csb",   32'(sram_csb), 32'd0);
      check_eq("fill_web",   32'(sram_web), 32'd0);
      check_eq("fill_addr",  32'(sram_a), 32'(c));
      check_eq("fill_data",  sram_i, 32'h0000_0000);
      check_eq("fill_rdy0",  32'(p0_req_ready), 32'd0);
      check_eq("fill_rdy1",  32'(p1_req_ready), 32'd0);
      next_cycle();
    end
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [8:0] a0, input logic [31:0] d0,
                       input logic v1, input logic w1, input logic [8:0] a1, input logic [31:0] d1);
    p0_req_valid = v0; p0_req_write = w0; p0_req_addr = a0; p0_req_wdata = d0;
    p1_req_valid = v1; p1_req_write = w1; p1_req_addr = a1; p1_req_wdata = d1;
  endtask

  initial begin
    sram_o = 32'h5555_5555;
    for (int i = 0; i < 512; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("rst_csb", 32'(sram_csb), 32'd1);
    check_eq("rst_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // 1. full fill with both ports requesting; readies stay low
    drive(1'b1, 1'b0, 9'h000, 32'd0, 1'b1, 1'b0, 9'h000, 32'd0);
    fill_cycles(0, 512);
    drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("done_512", 32'(init_done), 32'd1);
    check_eq("idle_csb", 32'(sram_csb), 32'd1);
    check_eq("idle_web", 32'(sram_web), 32'd1);
    check_eq("idle_oeb", 32'(sram_oeb), 32'd1);
    next_cycle();

    // 2. p0 reads last address -> filled value
    drive(1'b1, 1'b0, 9'h1FF, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("t2_rdy0", 32'(p0_req_ready), 32'd1);
    check_eq("t2_oeb",  32'(sram_oeb), 32'd0);
    check_eq("t2_addr", 32'(sram_a), 32'h1FF);
    next_cycle();
    drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("t2_rv0",  32'(p0_resp_valid), 32'd1);
    check_eq("t2_data", p0_resp_rdata, 32'h0000_0000);
    check_eq("t2_rv1",  32'(p1_resp_valid), 32'd0);
    next_cycle();

    // 3. write then read same address back to back
    drive(1'b1, 1'b1, 9'h005, 32'hDEAD_BEEF, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("t3_wrdy", 32'(p0_req_ready), 32'd1);
    check_eq("t3_web",  32'(sram_web), 32'd0);
    check_eq("t3_wdat", sram_i, 32'hDEAD_BEEF);
    next_cycle();
    drive(1'b1, 1'b0, 9'h005, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("t3_rrdy", 32'(p0_req_ready), 32'd1);
    check_eq("t3_norsp", 32'(p0_resp_valid), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("t3_rv0",  32'(p0_resp_valid), 32'd1);
    check_eq("t3_data", p0_resp_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // prepare data at 0x010/0x020; p0 then p1 leaves rr_ptr at 0
    drive(1'b1, 1'b1, 9'h010, 32'hCAFE_F00D, 1'b0, 1'b0, 9'd0, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b1, 9'h020, 32'h1234_5678);
    @(negedge clock);
    check_eq("prep_rdy1", 32'(p1_req_ready), 32'd1);
    next_cycle();

    // 4. contention: grants alternate p0,p1,p0,p1
    drive(1'b1, 1'b0, 9'h010, 32'd0, 1'b1, 1'b0, 9'h020, 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
      @(negedge clock);
      if (k < 4) begin
        check_eq("t4_rdy0", 32'(p0_req_ready), 32'(k % 2 == 0));
        check_eq("t4_rdy1", 32'(p1_req_ready), 32'(k % 2 == 1));
        check_eq("t4_addr", 32'(sram_a), (k % 2 == 0) ? 32'h010 : 32'h020);
      end
      if (k > 0) begin
        check_eq("t4_rv0", 32'(p0_resp_valid), 32'(k % 2 == 1));
        check_eq("t4_rv1", 32'(p1_resp_valid), 32'(k % 2 == 0));
        check_eq("t4_data", (k % 2 == 1) ? p0_resp_rdata : p1_resp_rdata,
                 (k % 2 == 1) ? 32'hCAFE_F00D : 32'h1234_5678);
      end
      next_cycle();
    end

    // 6. reset right after a read is accepted: no response pulse
    drive(1'b1, 1'b0, 9'h005, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("t6_rdy0", 32'(p0_req_ready), 32'd1);
    next_cycle();
    reset_n = 1'b0;
    @(negedge clock);
    check_eq("t6_rv0a", 32'(p0_resp_valid), 32'd0);
    check_eq("t6_csb",  32'(sram_csb), 32'd1);
    check_eq("t6_web",  32'(sram_web), 32'd1);
    check_eq("t6_oeb",  32'(sram_oeb), 32'd1);
    check_eq("t6_rdy0r", 32'(p0_req_ready), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("t6_rv0b", 32'(p0_resp_valid), 32'd0);
    check_eq("t6_done", 32'(init_done), 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // 5. interrupt fill at address 100, restart from 0
    fill_cycles(0, 100);
    @(negedge clock);
    check_eq("t5_at100", 32'(sram_a), 32'd100);
    reset_n = 1'b0;
    #1;
    check_eq("t5_csb", 32'(sram_csb), 32'd1);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    fill_cycles(0, 512);
    @(negedge clock);
    check_eq("t5_done", 32'(init_done), 32'd1);
    next_cycle();

    // refill overwrote earlier data
    drive(1'b1, 1'b0, 9'h005, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    check_eq("refill_rv", 32'(p0_resp_valid), 32'd1);
    check_eq("refill_data", p0_resp_rdata, 32'h0000_0000);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
